counter_timestamp_capture: RTL
==============================

Name: counter_timestamp_capture

Overview:
- Sits directly downstream of the free-running 128-bit counter; its `count_in` is driven by the counter's result bus.
- On each rising edge of an asynchronous event input, the block captures the current count into a small first-word-fall-through (FWFT) FIFO.
- Timestamps are delivered to the consumer over a valid/ready handshake.
- Drops caused by a full FIFO are flagged and counted.

Parameters:
- WIDTH, 128, width of `count_in` and `ts_data`.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, synchronizer flops on `event_in`; minimum 2.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on posedge clk.
- count_in  input  WIDTH  live count value from the upstream counter.
- event_in  input  1  asynchronous trigger; one capture per rising edge.
- ts_data  output  WIDTH  FIFO head timestamp.
- ts_valid  output  1  head entry present.
- ts_ready  input  1  consumer accepts head.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a capture is dropped.
- drop_count  output  8  saturating count of dropped captures.
- clear_ovf  input  1  clears `overflow` and `drop_count`.

Behaviour:
- Reset (reset==0 at a posedge):
  - `ts_valid`=0, `ts_data`=0, `level`=0, `overflow`=0, `drop_count`=0.
  - FIFO pointers=0; synchronizer and edge-history flops=0.
  - Reset overrides every other input in the same cycle.
  - Reset mid-operation discards all stored entries.
- Synchronizer:
  - `event_in` passes through SYNC_STAGES flops, then one history flop.
  - det = sync_out & ~history (combinational).
- Capture:
  - At a posedge where det==1, write `count_in` as sampled at that same edge.
  - Latency: `event_in` rising before edge k gives capture at edge k+SYNC_STAGES; with default settings, edge k+2.
  - `event_in` high and low phases must each be at least SYNC_STAGES+1 clk cycles; narrower pulses may be lost.
  - If `event_in` is high when reset is released, that counts as a rising edge: one capture occurs.
- FIFO:
  - FWFT: `ts_data` always equals the head entry whenever `ts_valid`=1.
  - A push into an empty FIFO at edge k gives `ts_valid`=1 after edge k, i.e. one-cycle latency to output.
  - Pop occurs at a posedge with `ts_valid` & `ts_ready`.
  - `ts_data` holds its last value when empty; it is 0 after reset.
  - `ts_data` and `ts_valid` are stable while `ts_valid`=1 and `ts_ready`=0.
  - `ts_ready` with `ts_valid`=0 is ignored.
  - Pointers wrap modulo DEPTH; `level` = writes − reads.
- Full (level==DEPTH):
  - With det==1 and no pop at that edge: capture dropped, `overflow`←1, `drop_count` increments, saturating at 255.
  - With det==1 and a pop at the same edge: capture accepted, `level` unchanged, no overflow.
- Empty with det==1: push only, `level` becomes 1.
- Simultaneous push and pop, not full: both occur, `level` unchanged.
- clear_ovf:
  - Normally clears `overflow`→0 and `drop_count`→0 at the next edge.
  - If a drop occurs at the same edge, set wins: `overflow`=1, `drop_count`=1.
- Arithmetic: stored value is `count_in` bit-exact; no offset or compensation. The consumer subtracts the fixed SYNC_STAGES latency if required.

Test Plan:
- Reset then idle, with `count_in` ramping by 1 per cycle → `ts_valid`=0, `level`=0, `overflow`=0, `drop_count`=0, `ts_data`=0.
- `event_in` rises before the edge where `count_in`=100, `ts_ready`=1 → capture at edge with `count_in`=102; `ts_valid`=1 next cycle with `ts_data`=102, popped the cycle after.
- `ts_ready`=0, six well-spaced events → `level`=4, `overflow`=1, `drop_count`=2; raising `ts_ready` drains the first 4 timestamps in order, strictly increasing.
- FIFO full, event edge coincident with a pop → new timestamp accepted; `level` stays 4; `overflow` stays 0.
- `overflow`=1, `clear_ovf` asserted at the same edge as a new drop → `overflow`=1, `drop_count`=1; `clear_ovf` alone next → both 0.
- `reset`=0 for one cycle with 3 entries queued → `level`=0, `ts_valid`=0. `count_in`=2^128−1 captured → `ts_data`=all-ones. Next capture after wrap → `ts_data`=small value; no sign or width error.

Source files
------------

// File: rtl/counter_timestamp_capture.sv
// rtl/counter_timestamp_capture.sv - captures a live count on event rising edges into a FWFT FIFO
module counter_timestamp_capture #(
    parameter int WIDTH       = 128,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         count_in,
    input  logic                     event_in,
    output logic [WIDTH-1:0]         ts_data,
    output logic                     ts_valid,
    input  logic                     ts_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    input  logic                     clear_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   history_q;
    logic                   det;

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          rd_next;
    logic [AW:0]            level_q;
    logic [AW:0]            level_next;
    logic [WIDTH-1:0]       head_q;
    logic [WIDTH-1:0]       head_next;
    logic                   head_load;

    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic                   ovf_q;
    logic [7:0]             drop_q;

    // Reset clears the history flop too, so an event held high through reset counts as an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q    <= '0;
            history_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], event_in};
            history_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign det     = sync_q[SYNC_STAGES-1] & ~history_q;
    assign full    = (level_q == FULL_LEVEL);
    assign pop     = ts_valid & ts_ready;
    assign push    = det & (~full | pop);
    assign drop    = det & full & ~pop;
    assign rd_next = rd_ptr + 1'b1;

    always_comb begin
        level_next = level_q;
        if (push && !pop) begin
            level_next = level_q + 1'b1;
        end else if (pop && !push) begin
            level_next = level_q - 1'b1;
        end
    end

    // The head register mirrors the entry that will be at rd_ptr after this edge;
    // when the FIFO drains it simply keeps its last value.
    always_comb begin
        head_load = 1'b0;
        head_next = head_q;
        if (pop) begin
            if (level_q > 1) begin
                head_load = 1'b1;
                head_next = mem[rd_next];
            end else if (push) begin
                head_load = 1'b1;
                head_next = count_in;
            end
        end else if (level_q == 0 && push) begin
            head_load = 1'b1;
            head_next = count_in;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= count_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            head_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            level_q <= level_next;
            if (head_load) begin
                head_q <= head_next;
            end
        end
    end

    // A drop in the same cycle as clear_ovf wins and restarts the count at one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_q  <= 1'b0;
            drop_q <= 8'd0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (clear_ovf) begin
                drop_q <= 8'd1;
            end else if (drop_q != 8'hff) begin
                drop_q <= drop_q + 8'd1;
            end
        end else if (clear_ovf) begin
            ovf_q  <= 1'b0;
            drop_q <= 8'd0;
        end
    end

    assign ts_data    = head_q;
    assign ts_valid   = (level_q != '0);
    assign level      = level_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule
